// File: rtl/pkt_ingress_checker.sv
// Store-and-forward framing checker for the 134-bit packet stream.
// Packets are written into a circular buffer and committed only once the tail
// proves the framing, length and source flag are good; committed packets are
// then replayed back-to-back with a minimum inter-packet gap.
module pkt_ingress_checker #(
    parameter int unsigned AW  = 8,
    parameter int unsigned GAP = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] in_data,
    input  logic         in_data_wr,
    input  logic         in_valid,
    input  logic         in_valid_wr,
    output logic [133:0] pktin_data,
    output logic         pktin_data_wr,
    output logic         pktin_valid,
    output logic         pktin_valid_wr,
    output logic [31:0]  good_cnt,
    output logic [31:0]  drop_cnt
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_RX   = 2'd1;
    localparam logic [1:0] W_ERR  = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_SEND = 2'd1;
    localparam logic [1:0] R_GAP  = 2'd2;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    localparam logic [AW-1:0] PtrOne  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    GapLast = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam logic          NoGap   = (GAP == 0);

    logic [133:0]  mem [2**AW];

    logic [1:0]    wstate_q, wstate_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] commit_ptr_q, commit_ptr_d;
    logic [11:0]   len_q, len_d;
    logic [11:0]   words_q, words_d;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          good_inc, drop_inc;

    logic [1:0]    in_tag;
    logic [AW-1:0] base_ptr;
    logic          full;
    logic [11:0]   words_tail;
    logic [11:0]   calc_len;
    logic          pkt_ok;

    logic [1:0]    rstate_q;
    logic [AW-1:0] rd_ptr_q;
    logic [3:0]    gap_cnt_q;
    logic [133:0]  rd_word;
    logic          rd_issue;
    logic          rd_tail;

    assign in_tag = in_data[133:132];
    // A head arriving mid-packet restarts writing from the last commit point.
    assign base_ptr   = (in_tag == TAG_HEAD && wstate_q != W_IDLE) ? commit_ptr_q : wr_ptr_q;
    assign full       = (base_ptr + PtrOne) == rd_ptr_q;
    assign words_tail = words_q + 12'd1;
    // Byte length is kept in 12 bits, so the word count is shifted modulo 4096.
    assign calc_len   = {words_tail[7:0], 4'b0000} - {8'd0, in_data[131:128]};
    assign pkt_ok     = !full && (calc_len == len_q) && in_valid_wr && in_valid;

    // Write FSM next state: buffer writes, commit/rollback and counter strobes.
    always_comb begin
        wstate_d     = wstate_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        words_d      = words_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr_q;
        good_inc     = 1'b0;
        drop_inc     = 1'b0;
        if (in_data_wr) begin
            if (in_tag == TAG_HEAD) begin
                if (wstate_q != W_IDLE) begin
                    drop_inc = 1'b1;
                    wr_ptr_d = commit_ptr_q;
                end
                len_d   = in_data[107:96];
                words_d = 12'd1;
                if (full) begin
                    wstate_d = W_ERR;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = base_ptr;
                    wr_ptr_d  = base_ptr + PtrOne;
                    wstate_d  = W_RX;
                end
            end else begin
                case (wstate_q)
                    W_IDLE: begin
                        if (in_tag == TAG_TAIL) drop_inc = 1'b1;
                    end
                    W_RX: begin
                        if (in_tag == TAG_MID) begin
                            if (full) begin
                                wstate_d = W_ERR;
                            end else begin
                                mem_we   = 1'b1;
                                wr_ptr_d = wr_ptr_q + PtrOne;
                                words_d  = words_tail;
                            end
                        end else if (in_tag == TAG_TAIL) begin
                            wstate_d = W_IDLE;
                            if (pkt_ok) begin
                                mem_we       = 1'b1;
                                wr_ptr_d     = wr_ptr_q + PtrOne;
                                commit_ptr_d = wr_ptr_q + PtrOne;
                                good_inc     = 1'b1;
                            end else begin
                                wr_ptr_d = commit_ptr_q;
                                drop_inc = 1'b1;
                            end
                        end else begin
                            // Unknown tag: treat the packet as malformed.
                            wstate_d = W_ERR;
                        end
                    end
                    W_ERR: begin
                        if (in_tag == TAG_TAIL) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_inc = 1'b1;
                            wstate_d = W_IDLE;
                        end
                    end
                    default: wstate_d = W_IDLE;
                endcase
            end
        end
    end

    // Write-side state, pointers and packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q     <= W_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            len_q        <= '0;
            words_q      <= '0;
            good_cnt     <= '0;
            drop_cnt     <= '0;
        end else begin
            wstate_q     <= wstate_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            len_q        <= len_d;
            words_q      <= words_d;
            if (good_inc) good_cnt <= good_cnt + 32'd1;
            if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
        end
    end

    // Packet buffer storage.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= in_data;
    end

    assign rd_word  = mem[rd_ptr_q];
    assign rd_tail  = rd_word[133:132] == TAG_TAIL;
    // Only committed words are readable, so once SEND starts it never starves.
    assign rd_issue = (rstate_q == R_SEND) || (rstate_q == R_IDLE && rd_ptr_q != commit_ptr_q);

    // Read FSM: replay committed packets with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q       <= R_IDLE;
            rd_ptr_q       <= '0;
            gap_cnt_q      <= '0;
            pktin_data     <= '0;
            pktin_data_wr  <= 1'b0;
            pktin_valid    <= 1'b0;
            pktin_valid_wr <= 1'b0;
        end else begin
            pktin_data     <= rd_issue ? rd_word : '0;
            pktin_data_wr  <= rd_issue;
            pktin_valid    <= rd_issue && rd_tail;
            pktin_valid_wr <= rd_issue && rd_tail;
            if (rd_issue) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
                if (rd_tail) begin
                    rstate_q  <= NoGap ? R_IDLE : R_GAP;
                    gap_cnt_q <= '0;
                end else begin
                    rstate_q <= R_SEND;
                end
            end else if (rstate_q == R_GAP) begin
                if (gap_cnt_q == GapLast) rstate_q <= R_IDLE;
                else                      gap_cnt_q <= gap_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_ingress_checker.sv
// Self-checking bench for pkt_ingress_checker: a large-buffer and a small-buffer
// instance share the input stream; a packet-level reference model predicts what
// each one forwards and how the good/drop counters move.
module tb_pkt_ingress_checker;

    localparam int unsigned GAP = 2;
    localparam int          CAP_BIG   = 255;
    localparam int          CAP_SMALL = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [133:0] in_data;
    logic         in_data_wr, in_valid, in_valid_wr;

    logic [133:0] b_data, s_data;
    logic         b_wr, b_v, b_vwr, s_wr, s_v, s_vwr;
    logic [31:0]  b_good, b_drop, s_good, s_drop;

    pkt_ingress_checker #(.AW(8), .GAP(GAP)) u_big (
        .clk(clk), .rst(rst), .in_data(in_data), .in_data_wr(in_data_wr),
        .in_valid(in_valid), .in_valid_wr(in_valid_wr),
        .pktin_data(b_data), .pktin_data_wr(b_wr), .pktin_valid(b_v),
        .pktin_valid_wr(b_vwr), .good_cnt(b_good), .drop_cnt(b_drop)
    );

    pkt_ingress_checker #(.AW(4), .GAP(GAP)) u_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_data_wr(in_data_wr),
        .in_valid(in_valid), .in_valid_wr(in_valid_wr),
        .pktin_data(s_data), .pktin_data_wr(s_wr), .pktin_valid(s_v),
        .pktin_valid_wr(s_vwr), .good_cnt(s_good), .drop_cnt(s_drop)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [133:0] exp_q[$];
    logic [133:0] exp_s_q[$];
    logic [133:0] cur_pkt[$];
    int exp_good = 0, exp_drop = 0, exp_s_good = 0, exp_s_drop = 0;
    bit small_en = 1'b0;

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference rule: length in 12-bit bytes must match, source must flag it
    // good, and the whole packet must fit in an empty buffer of the given size.
    function automatic bit pkt_good(input int cap, input bit v, input bit vwr);
        int n;
        int bytes;
        logic [133:0] hd;
        logic [133:0] tl;
        logic [11:0] calc;
        n = cur_pkt.size();
        hd = cur_pkt[0];
        tl = cur_pkt[n-1];
        bytes = n * 16 - int'(tl[131:128]);
        calc = bytes[11:0];
        return (calc == hd[107:96]) && v && vwr && (n <= cap);
    endfunction

    task automatic build(input int n, input int inv, input int len_delta);
        logic [133:0] w;
        int bytes;
        cur_pkt.delete();
        for (int i = 0; i < n; i++) begin
            w = {2'b11, 4'd0, $urandom, $urandom, $urandom, $urandom};
            if (i == 0) begin
                bytes = n * 16 - inv + len_delta;
                w[133:132] = 2'b01;
                w[107:96]  = bytes[11:0];
            end
            if (i == n - 1) begin
                w[133:132] = 2'b10;
                w[131:128] = inv[3:0];
            end
            cur_pkt.push_back(w);
        end
    endtask

    // Drive the first nsend words of cur_pkt back to back and update the model.
    task automatic send(input int nsend, input bit v, input bit vwr);
        bit last;
        for (int i = 0; i < nsend; i++) begin
            last        = (i == cur_pkt.size() - 1);
            in_data     = cur_pkt[i];
            in_data_wr  = 1'b1;
            in_valid    = last & v;
            in_valid_wr = last & vwr;
            @(posedge clk);
            #1;
        end
        in_data = '0;
        in_data_wr = 1'b0;
        in_valid = 1'b0;
        in_valid_wr = 1'b0;
        if (nsend < cur_pkt.size()) begin
            exp_drop++;
            if (small_en) exp_s_drop++;
        end else begin
            if (pkt_good(CAP_BIG, v, vwr)) begin
                foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
                exp_good++;
            end else begin
                exp_drop++;
            end
            if (small_en) begin
                if (pkt_good(CAP_SMALL, v, vwr)) begin
                    foreach (cur_pkt[i]) exp_s_q.push_back(cur_pkt[i]);
                    exp_s_good++;
                end else begin
                    exp_s_drop++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || exp_s_q.size() != 0); i++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check(tag, 134'(exp_q.size() + exp_s_q.size()), 134'(0));
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_good"}, 134'(b_good), 134'(exp_good));
        check({tag, "_drop"}, 134'(b_drop), 134'(exp_drop));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, b_data, 134'(0));
        check({tag, "_wr"}, 134'(b_wr), 134'(0));
        check({tag, "_valid"}, 134'(b_v), 134'(0));
        check({tag, "_valid_wr"}, 134'(b_vwr), 134'(0));
        check({tag, "_good"}, 134'(b_good), 134'(0));
        check({tag, "_drop"}, 134'(b_drop), 134'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_s_q.delete();
        exp_good = 0;
        exp_drop = 0;
        exp_s_good = 0;
        exp_s_drop = 0;
    endtask

    // Output monitor for the large instance: content, tail flags, contiguity, gap.
    initial begin
        logic [133:0] w;
        bit in_pkt;
        bit seen_pkt;
        int idle_cnt;
        in_pkt = 1'b0;
        seen_pkt = 1'b0;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pkt = 1'b0;
                seen_pkt = 1'b0;
                idle_cnt = 0;
            end else if (b_wr) begin
                if (exp_q.size() == 0) begin
                    check("big_unexpected_word", 134'(b_wr), 134'(0));
                end else begin
                    w = exp_q.pop_front();
                    if (w[133:132] == 2'b01 && seen_pkt)
                        check("big_gap", 134'(idle_cnt >= GAP), 134'(1));
                    check("big_data", b_data, w);
                    check("big_valid", 134'(b_v), 134'(w[133:132] == 2'b10));
                    check("big_valid_wr", 134'(b_vwr), 134'(w[133:132] == 2'b10));
                    in_pkt = (w[133:132] != 2'b10);
                    if (w[133:132] == 2'b10) seen_pkt = 1'b1;
                end
                idle_cnt = 0;
            end else begin
                if (in_pkt) begin
                    check("big_contig", 134'(b_wr), 134'(1));
                    in_pkt = 1'b0;
                end
                idle_cnt++;
            end
        end
    end

    // Output monitor for the small instance, active only in the overflow section.
    initial begin
        logic [133:0] w;
        forever begin
            @(negedge clk);
            if (small_en && !rst && s_wr) begin
                if (exp_s_q.size() == 0) begin
                    check("small_unexpected_word", 134'(s_wr), 134'(0));
                end else begin
                    w = exp_s_q.pop_front();
                    check("small_data", s_data, w);
                    check("small_valid_wr", 134'(s_vwr), 134'(w[133:132] == 2'b10));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        rst = 1'b1;
        in_data = '0;
        in_data_wr = 1'b0;
        in_valid = 1'b0;
        in_valid_wr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        idle(1);

        // Single 7-word packet: length 0x6e, tail invalid 2, first output at t+2.
        build(7, 2, 0);
        send(7, 1, 1);
        @(negedge clk);
        check("lat_t1_wr", 134'(b_wr), 134'(0));
        check_cnt("single_tail_edge");
        @(negedge clk);
        check("lat_t2_wr", 134'(b_wr), 134'(1));
        drain("single_drain");
        check_cnt("single");

        // Length field off by one, then a correct packet.
        build(7, 2, 1);
        send(7, 1, 1);
        idle(2);
        build(7, 2, 0);
        send(7, 1, 1);
        drain("mismatch_drain");
        check_cnt("mismatch");

        // Head plus three middles with no tail, followed by a good packet.
        build(7, 2, 0);
        send(4, 1, 1);
        build(7, 2, 0);
        send(7, 1, 1);
        drain("notail_drain");
        check_cnt("notail");

        // Source-flagged bad, missing strobe, then 50 random good packets.
        build(7, 2, 0);
        send(7, 0, 1);
        idle(2);
        build(5, 3, 0);
        send(5, 1, 0);
        idle(2);
        for (int k = 0; k < 50; k++) begin
            n = $urandom_range(2, 12);
            build(n, $urandom_range(0, 15), 0);
            send(n, 1, 1);
            idle(2);
        end
        drain("burst_drain");
        check_cnt("burst");

        // Overflow boundaries on the 15-word buffer and the 255-word buffer.
        do_reset();
        small_en = 1'b1;
        build(20, 5, 0);
        send(20, 1, 1);
        drain("ovf20_drain");
        check("ovf20_small_drop", 134'(s_drop), 134'(exp_s_drop));
        build(7, 2, 0);
        send(7, 1, 1);
        drain("ovf_follow_drain");
        check("ovf_follow_small_good", 134'(s_good), 134'(exp_s_good));
        build(15, 0, 0);
        send(15, 1, 1);
        drain("cap15_drain");
        build(16, 0, 0);
        send(16, 1, 1);
        drain("cap16_drain");
        check("cap_small_good", 134'(s_good), 134'(exp_s_good));
        check("cap_small_drop", 134'(s_drop), 134'(exp_s_drop));
        build(256, 1, 0);
        send(256, 1, 1);
        drain("ovf256_drain");
        check_cnt("ovf256");
        small_en = 1'b0;

        // Reset during the third output word.
        build(7, 2, 0);
        send(7, 1, 1);
        seen = 0;
        for (int i = 0; i < 50 && seen < 3; i++) begin
            @(negedge clk);
            if (b_wr) seen++;
        end
        check("rst_word3_reached", 134'(seen), 134'(3));
        rst = 1'b1;
        exp_q.delete();
        exp_s_q.delete();
        exp_good = 0;
        exp_drop = 0;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        idle(1);
        build(7, 2, 0);
        send(7, 1, 1);
        @(negedge clk);
        check("post_rst_lat_t1_wr", 134'(b_wr), 134'(0));
        @(negedge clk);
        check("post_rst_lat_t2_wr", 134'(b_wr), 134'(1));
        drain("post_rst_drain");
        check_cnt("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
